rd_bus_arbiter: RTL and testbench



---
 rtl/rd_arb_pkg.sv | 16 +
 rtl/rd_bus_arbiter_rr_picker.sv | 32 +++
 rtl/rd_bus_arbiter.sv | 107 ++++++++++
 tb/tb_rd_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_arb_pkg.sv
// Shared types for the wait-state read bus arbiter: FSM encoding and counter sizing.
package rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DLY  = 2'b11,
    DONE = 2'b10
  } state_t;

  // Width needed to count 0..max_ws retries inclusive.
  function automatic int ws_cnt_width(input int max_ws);
    return (max_ws < 1) ? 1 : $clog2(max_ws + 1);
  endfunction

endpackage

// File: rtl/rd_bus_arbiter_rr_picker.sv
// Round-robin pick: first requesting index at or after ptr, wrapping modulo NREQ.
import rd_arb_pkg::*;

module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);

  int k;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    k    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) begin
        pick    = '0;
        pick[k] = 1'b1;
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rd_bus_arbiter.sv
// Shares one wait-state read bus between NREQ requesters; sequences READ/DLY/DONE
// cycles with ws stretching and a wait-state timeout that ends the cycle with err.
import rd_arb_pkg::*;

module rd_bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int MAX_WS = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] addr_i,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  err,
  output logic [DW-1:0]    rdata_o,
  output logic             rd,
  output logic [AW-1:0]    addr_o,
  input  logic             ws,
  input  logic [DW-1:0]    rdata_i,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held until done[i]; done[i] pulses for exactly one
  // cycle (with err[i] on timeout) and rdata_o is valid only while done[i] is high.

  localparam int IW  = $clog2(NREQ);
  localparam int WSW = ws_cnt_width(MAX_WS);
  localparam logic [WSW-1:0] WS_LIMIT = WSW'(MAX_WS);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [WSW-1:0]  ws_cnt;
  logic            err_q;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] owner_oh;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      ws_cnt  <= '0;
      err_q   <= 1'b0;
      addr_o  <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            owner  <= pick_idx;
            addr_o <= addr_i[int'(pick_idx)*AW +: AW];
            ws_cnt <= '0;
            err_q  <= 1'b0;
            state  <= READ;
          end
        end
        READ: state <= DLY;
        DLY: begin
          if (!ws) begin
            rdata_o <= rdata_i;
            err_q   <= 1'b0;
            state   <= DONE;
          end else if (ws_cnt < WS_LIMIT) begin
            ws_cnt <= ws_cnt + WSW'(1);
            state  <= READ;
          end else begin
            // Timeout: report an error with zeroed data rather than stale bus data.
            rdata_o <= '0;
            err_q   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          state <= IDLE;
        end
      endcase
    end
  end

  assign owner_oh = NREQ'(1) << owner;

  // Outputs decode only registered state, so req/ws never reach them combinationally.
  always_comb begin
    gnt       = (state != IDLE) ? owner_oh : '0;
    done      = (state == DONE) ? owner_oh : '0;
    err       = (state == DONE && err_q) ? owner_oh : '0;
    rd        = (state == READ) || (state == DLY);
    state_dbg = state;
  end

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Self-checking bench for rd_bus_arbiter: scenario tasks with a completion scoreboard.
module tb_rd_bus_arbiter;

  localparam int NREQ   = 4;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int MAX_WS = 15;
  localparam int EW     = NREQ + 1 + DW + AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ-1:0]   gnt, done, err;
  logic [DW-1:0]     rdata_o, rdata_i;
  logic              rd, ws;
  logic [AW-1:0]     addr_o;
  logic [1:0]        state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  logic [NREQ-1:0] obs_done, obs_err, obs_gnt;
  logic [DW-1:0]   obs_rdata;
  logic [AW-1:0]   obs_addr;
  logic            obs_rd;

  rd_bus_arbiter #(
    .NREQ (NREQ), .AW (AW), .DW (DW), .MAX_WS (MAX_WS)
  ) dut (
    .clk (clk), .rst_n (rst_n), .req (req), .addr_i (addr_i),
    .gnt (gnt), .done (done), .err (err), .rdata_o (rdata_o),
    .rd (rd), .addr_o (addr_o), .ws (ws), .rdata_i (rdata_i),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [EW-1:0] pack_exp(input int own, input logic e,
                                             input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[own] = 1'b1;
    return {oh, e, d, a};
  endfunction

  task automatic push_grant(input logic e, input logic [DW-1:0] d);
    int own;
    own = model_pick(req, model_ptr);
    exp_q.push_back(pack_exp(own, e, e ? '0 : d, addr_i[own*AW +: AW]));
    model_ptr = (own + 1) % NREQ;
  endtask

  task automatic wait_done(input int limit, input int ws_rel, input int addr_chg,
                           input int drop_at, output int n, output int rdc, output bit got);
    n = 0; rdc = 0; got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (rd) rdc++;
      if (|done) begin
        got = 1'b1;
        obs_done = done; obs_err = err; obs_rdata = rdata_o;
        obs_addr = addr_o; obs_gnt = gnt; obs_rd = rd;
      end else begin
        if (n == ws_rel) ws = 1'b0;
        if (n == addr_chg) addr_i = ~addr_i;
        if (n == drop_at) req = '0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; ws = 1'b0; addr_i = '0; rdata_i = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, done, err, rd, addr_o, rdata_o, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got gnt=%b done=%b err=%b rd=%b addr=%h rdata=%h st=%b exp all 0",
               gnt, done, err, rd, addr_o, rdata_o, state_dbg);
    end
    rst_n = 1'b1; model_ptr = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, rd, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b rd=%b st=%b exp 0", gnt, rd, state_dbg);
    end
  endtask

  task automatic test_single();
    int n, rdc; bit got; logic [EW-1:0] e;
    req = 4'b0001; addr_i = {$urandom, $urandom}; addr_i[7:0] = 8'h3C;
    rdata_i = DW'($urandom); ws = 1'b0;
    push_grant(1'b0, rdata_i);
    wait_done(20, 0, 0, 0, n, rdc, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL single_done: no done within 20 cycles"); end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL single_latency: got %0d exp 3", n); end
    n_checks++;
    if (rdc !== 2) begin n_fail++; $display("FAIL single_rd_cycles: got %0d exp 2", rdc); end
    e = exp_q.pop_front();
    n_checks++;
    if ({obs_done, obs_err[0], obs_rdata, obs_addr} !== e) begin
      n_fail++;
      $display("FAIL single_result: got %h exp %h", {obs_done, obs_err[0], obs_rdata, obs_addr}, e);
    end
    n_checks++;
    if (obs_gnt !== 4'b0001 || obs_rd !== 1'b0 || obs_err !== '0) begin
      n_fail++;
      $display("FAIL single_done_state: got gnt=%b rd=%b err=%b exp 0001/0/0000", obs_gnt, obs_rd, obs_err);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if ({gnt, done, rd} !== '0) begin
      n_fail++;
      $display("FAIL single_back_idle: got gnt=%b done=%b rd=%b exp 0", gnt, done, rd);
    end
  endtask

  task automatic test_back_to_back();
    int n, rdc; bit got; logic [EW-1:0] e; logic [NREQ-1:0] eoh;
    int order[5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; model_ptr = 0;
    addr_i = {$urandom}; ws = 1'b0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rdata_i = DW'($urandom);
      push_grant(1'b0, rdata_i);
      wait_done(20, 0, 0, 0, n, rdc, got);
      n_checks++;
      if (!got || n !== ((k == 0) ? 3 : 4)) begin
        n_fail++;
        $display("FAIL rr_spacing[%0d]: got %0d cycles (done seen %0b) exp %0d", k, n, got, (k == 0) ? 3 : 4);
      end
      eoh = 4'b0001 << order[k];
      n_checks++;
      if (obs_done !== eoh) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got done=%b exp %b", k, obs_done, eoh);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_done, obs_err[0], obs_rdata, obs_addr} !== e) begin
        n_fail++;
        $display("FAIL rr_result[%0d]: got %h exp %h", k, {obs_done, obs_err[0], obs_rdata, obs_addr}, e);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int n, rdc; bit got; logic [EW-1:0] e;
    req = 4'b0100; addr_i = {$urandom}; rdata_i = DW'($urandom); ws = 1'b1;
    push_grant(1'b0, rdata_i);
    // ws high for the DLY samples at cycles 2 and 4, low for cycle 6; addr_i scrambled after grant
    wait_done(30, 5, 2, 0, n, rdc, got);
    n_checks++;
    if (!got || n !== 7) begin
      n_fail++;
      $display("FAIL ws_latency: got %0d cycles (done seen %0b) exp 7", n, got);
    end
    n_checks++;
    if (rdc !== 6) begin n_fail++; $display("FAIL ws_rd_cycles: got %0d exp 6", rdc); end
    e = exp_q.pop_front();
    n_checks++;
    if ({obs_done, obs_err[2], obs_rdata, obs_addr} !== e || obs_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL ws_result: got %h gnt=%b exp %h gnt=0100",
               {obs_done, obs_err[2], obs_rdata, obs_addr}, obs_gnt, e);
    end
    req = '0; ws = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, rdc; bit got; logic [EW-1:0] e;
    req = 4'b0010; addr_i = {$urandom}; rdata_i = DW'($urandom); ws = 1'b1;
    push_grant(1'b1, rdata_i);
    wait_done(60, 0, 0, 0, n, rdc, got);
    n_checks++;
    if (!got || n !== 3 + 2 * MAX_WS) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles (done seen %0b) exp %0d", n, got, 3 + 2 * MAX_WS);
    end
    n_checks++;
    if (rdc !== 2 * (MAX_WS + 1)) begin
      n_fail++;
      $display("FAIL timeout_rd_cycles: got %0d exp %0d", rdc, 2 * (MAX_WS + 1));
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({obs_done, obs_err[1], obs_rdata, obs_addr} !== e || obs_err !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_result: got %h err=%b exp %h err=0010",
               {obs_done, obs_err[1], obs_rdata, obs_addr}, obs_err, e);
    end
    req = '0; ws = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    int n, rdc; bit got; logic [EW-1:0] e;
    req = 4'b1000; addr_i = {$urandom}; addr_i[31:24] = 8'hA5; rdata_i = DW'($urandom); ws = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'b11 || gnt !== 4'b1000 || rd !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_dly: got st=%b gnt=%b rd=%b exp 11/1000/1", state_dbg, gnt, rd);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, done, err, rd, addr_o, rdata_o, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got gnt=%b done=%b err=%b rd=%b addr=%h rdata=%h st=%b exp all 0",
               gnt, done, err, rd, addr_o, rdata_o, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1; model_ptr = 0;
    req = 4'b1001; addr_i = {$urandom}; rdata_i = DW'($urandom);
    push_grant(1'b0, rdata_i);
    wait_done(20, 0, 0, 0, n, rdc, got);
    n_checks++;
    if (!got || n !== 3 || obs_done !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_grant: got done=%b after %0d cycles exp 0001 after 3", obs_done, n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({obs_done, obs_err[0], obs_rdata, obs_addr} !== e) begin
      n_fail++;
      $display("FAIL post_reset_result: got %h exp %h", {obs_done, obs_err[0], obs_rdata, obs_addr}, e);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    int n, rdc, bad; bit got; logic [EW-1:0] e;
    req = 4'b0001; addr_i = {$urandom}; rdata_i = DW'($urandom); ws = 1'b0;
    push_grant(1'b0, rdata_i);
    wait_done(20, 0, 0, 1, n, rdc, got);
    n_checks++;
    if (!got || n !== 3) begin
      n_fail++;
      $display("FAIL drop_done: got %0d cycles (done seen %0b) exp done after 3", n, got);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({obs_done, obs_err[0], obs_rdata, obs_addr} !== e) begin
      n_fail++;
      $display("FAIL drop_result: got %h exp %h", {obs_done, obs_err[0], obs_rdata, obs_addr}, e);
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gnt !== '0 || done !== '0 || rd !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL drop_no_regrant: got %0d busy cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid_cycle();
    test_req_drop();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
